gf_poly_eval: RTL and testbench

GF_POLY_EVAL -- requirements
Module: gf_poly_eval

---
 rtl/gf_poly_eval.sv | 104 ++++++++++
 tb/tb_gf_poly_eval.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_poly_eval.sv
// gf_poly_eval: captures a GF(2^m) polynomial on vld_i and evaluates it at symb
// with Horner's scheme for EVAL_CYCLES cycles after each capture.
// Optional registered output stage: define GF_POLY_EVAL_OUTREG_EN.
//   defined   -> eval_value/vld_o registered, symb sampled the cycle before the edge
//   undefined -> eval_value is the combinational result gated by the active window
module gf_poly_eval #(
  parameter int                  SYMB_WIDTH  = 8,
  parameter int                  T_LEN       = 8,
  parameter logic [SYMB_WIDTH:0] PRIM_POLY   = 9'h11D,
  parameter int                  EVAL_CYCLES = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              vld_i,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]    poly,
  input  logic [T_LEN-1:0]                  poly_sel,
  input  logic [SYMB_WIDTH-1:0]             symb,
  output logic [SYMB_WIDTH-1:0]             eval_value,
  output logic                              vld_o
);

  localparam logic [7:0] EVAL_LOAD = 8'(EVAL_CYCLES);

  logic [T_LEN:0][SYMB_WIDTH-1:0] coef_reg;
  logic [T_LEN:0][SYMB_WIDTH-1:0] coef_next;
  logic [7:0]                     cnt_reg;
  logic                           active;
  logic [SYMB_WIDTH-1:0]          acc;
  logic [SYMB_WIDTH-1:0]          comb_value;

  // GF(2^m) multiply: shift-and-add with reduction by the primitive polynomial
  function automatic logic [SYMB_WIDTH-1:0] gf_mul(input logic [SYMB_WIDTH-1:0] a,
                                                   input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] prod;
    logic [SYMB_WIDTH-1:0] aa;
    prod = '0;
    aa   = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) prod = prod ^ aa;
      aa = {aa[SYMB_WIDTH-2:0], 1'b0} ^ (aa[SYMB_WIDTH-1] ? PRIM_POLY[SYMB_WIDTH-1:0] : '0);
    end
    return prod;
  endfunction

  // The leading coefficient is always kept; the others are gated by poly_sel,
  // whose bit i controls coefficient T_LEN-1-i (MSB-first ordering).
  genvar gi;
  generate
    for (gi = 0; gi <= T_LEN; gi++) begin : g_cap
      if (gi == T_LEN) begin : g_lead
        assign coef_next[gi] = poly[gi];
      end else begin : g_gated
        assign coef_next[gi] = poly_sel[T_LEN-1-gi] ? poly[gi] : '0;
      end
    end
  endgenerate

  assign active = (cnt_reg != 8'd0);

  // Capture coefficients and (re)load the active window; count down otherwise
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      coef_reg <= '0;
      cnt_reg  <= '0;
    end else if (vld_i) begin
      coef_reg <= coef_next;
      cnt_reg  <= EVAL_LOAD;
    end else if (cnt_reg != 8'd0) begin
      cnt_reg  <= cnt_reg - 8'd1;
    end
  end

  // Horner evaluation from the leading coefficient down; symb^0 is implicitly 1
  always_comb begin
    acc = coef_reg[T_LEN];
    for (int j = T_LEN - 1; j >= 0; j--) begin
      acc = gf_mul(acc, symb) ^ coef_reg[j];
    end
    comb_value = acc;
  end

`ifdef GF_POLY_EVAL_OUTREG_EN
  logic [SYMB_WIDTH-1:0] val_reg;
  logic                  vld_reg;

  // Register the gated result and the active flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      val_reg <= '0;
      vld_reg <= 1'b0;
    end else begin
      val_reg <= active ? comb_value : '0;
      vld_reg <= active;
    end
  end

  assign eval_value = val_reg;
  assign vld_o      = vld_reg;
`else
  assign eval_value = active ? comb_value : '0;
  assign vld_o      = active;
`endif

endmodule

// File: tb/tb_gf_poly_eval.sv
// tb_gf_poly_eval: two instances (EVAL_CYCLES=1 and 4) share stimulus; a
// sum-of-powers GF(2^8) reference model predicts every cycle's outputs.
// Works with or without GF_POLY_EVAL_OUTREG_EN defined.
module tb_gf_poly_eval;

  localparam int W = 8;
  localparam int T = 8;
`ifdef GF_POLY_EVAL_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic               aclk;
  logic               aresetn;
  logic               vld_i;
  logic [T:0][W-1:0]  poly;
  logic [T-1:0]       poly_sel;
  logic [W-1:0]       symb;
  logic [W-1:0]       val1, val4;
  logic               vld1, vld4;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: captured coefficients and remaining active cycles
  logic [T:0][W-1:0]  c1, c4;
  int                 cnt1, cnt4;

  gf_poly_eval #(.SYMB_WIDTH(8), .T_LEN(8), .PRIM_POLY(9'h11D), .EVAL_CYCLES(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .vld_i(vld_i), .poly(poly), .poly_sel(poly_sel),
    .symb(symb), .eval_value(val1), .vld_o(vld1));

  gf_poly_eval #(.SYMB_WIDTH(8), .T_LEN(8), .PRIM_POLY(9'h11D), .EVAL_CYCLES(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .vld_i(vld_i), .poly(poly), .poly_sel(poly_sel),
    .symb(symb), .eval_value(val4), .vld_o(vld4));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // carry-less product followed by long division by x^8+x^4+x^3+x^2+1
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int prod;
    prod = 0;
    for (int i = 0; i < W; i++)
      if (b[i]) prod = prod ^ (int'(a) << i);
    for (int k = 2*W-2; k >= W; k--)
      if (((prod >> k) & 1) == 1) prod = prod ^ ('h11D << (k - W));
    return W'(prod);
  endfunction

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input int e);
    logic [W-1:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_eval(input logic [T:0][W-1:0] c, input logic [W-1:0] x);
    logic [W-1:0] s;
    s = '0;
    for (int j = 0; j <= T; j++) s = s ^ ref_mul(c[j], ref_pow(x, j));
    return s;
  endfunction

  function automatic logic [T:0][W-1:0] ref_capture(input logic [T:0][W-1:0] p, input logic [T-1:0] s);
    logic [T:0][W-1:0] c;
    for (int j = 0; j <= T; j++) begin
      if (j == T) c[j] = p[j];
      else        c[j] = s[T-1-j] ? p[j] : '0;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: drive inputs, predict, take the edge, compare both instances
  task automatic step(input logic v, input logic [T:0][W-1:0] p, input logic [T-1:0] s,
                      input logic [W-1:0] x);
    logic [W-1:0] e1, e4;
    logic         a1, a4;
    vld_i = v; poly = p; poly_sel = s; symb = x;
    a1 = (cnt1 != 0); a4 = (cnt4 != 0);
    e1 = a1 ? ref_eval(c1, x) : '0;
    e4 = a4 ? ref_eval(c4, x) : '0;
    if (v) begin
      c1 = ref_capture(p, s); cnt1 = 1;
      c4 = ref_capture(p, s); cnt4 = 4;
    end else begin
      if (cnt1 > 0) cnt1--;
      if (cnt4 > 0) cnt4--;
    end
    if (LAT == 0) begin
      a1 = (cnt1 != 0); a4 = (cnt4 != 0);
      e1 = a1 ? ref_eval(c1, x) : '0;
      e4 = a4 ? ref_eval(c4, x) : '0;
    end
    @(posedge aclk);
    #1;
    check("vld1", 32'(vld1), 32'(a1));
    check("val1", 32'(val1), 32'(e1));
    check("vld4", 32'(vld4), 32'(a4));
    check("val4", 32'(val4), 32'(e4));
  endtask

  task automatic model_reset();
    c1 = '0; c4 = '0; cnt1 = 0; cnt4 = 0;
  endtask

  // capture on dut1 and check its single valid output against a fixed value
  task automatic run1(input string tag, input logic [T:0][W-1:0] p, input logic [T-1:0] s,
                      input logic [W-1:0] x, input logic [W-1:0] exp);
    step(1'b1, p, s, x);
    if (LAT != 0) step(1'b0, p, s, x);
    check({tag, "_vld"}, 32'(vld1), 32'd1);
    check(tag, 32'(val1), 32'(exp));
    step(1'b0, p, s, x);
    check({tag, "_off"}, 32'(vld1), 32'd0);
  endtask

  logic [T:0][W-1:0] p;
  logic [T-1:0]      sel;
  logic [W-1:0]      exp36 [4];

  initial begin
    aresetn = 1'b0; vld_i = 1'b0; poly = '0; poly_sel = '0; symb = '0;
    model_reset();
    #1;
    check("rst_vld1", 32'(vld1), 32'd0);
    check("rst_val1", 32'(val1), 32'd0);
    check("rst_vld4", 32'(vld4), 32'd0);
    check("rst_val4", 32'(val4), 32'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // 1 + 2x at 0x8E evaluates to zero
    p = '0; p[0] = 8'h01; p[1] = 8'h02; sel = '1;
    run1("r032", p, sel, 8'h8E, 8'h00);

    // x^8 at alpha reduces to the primitive polynomial tail
    p = '0; p[8] = 8'h01;
    run1("r033", p, sel, 8'h02, 8'h1D);

    // x^7 at alpha, then gated off by poly_sel[0]
    p = '0; p[7] = 8'h01;
    run1("r034a", p, sel, 8'h02, 8'h80);
    run1("r034b", p, 8'hFE, 8'h02, 8'h00);

    // symb=0 yields the constant term only
    for (int j = 0; j <= T; j++) p[j] = 8'($urandom_range(1, 255));
    p[0] = 8'h5A;
    run1("r035", p, sel, 8'h00, 8'h5A);

    // x^2 over four cycles on dut4
    exp36[0] = 8'h01; exp36[1] = 8'h04; exp36[2] = 8'h10; exp36[3] = 8'h40;
    p = '0; p[2] = 8'h01;
    step(1'b1, p, sel, 8'h01);
    if (LAT != 0) step(1'b0, p, sel, 8'h01);
    check("r036_vld0", 32'(vld4), 32'd1);
    check("r036_val0", 32'(val4), 32'(exp36[0]));
    for (int i = 1; i < 4; i++) begin
      step(1'b0, p, sel, 8'(1 << i));
      check("r036_vld", 32'(vld4), 32'd1);
      check("r036_val", 32'(val4), 32'(exp36[i]));
    end
    step(1'b0, p, sel, 8'h10);
    check("r036_end_vld", 32'(vld4), 32'd0);
    check("r036_end_val", 32'(val4), 32'd0);

    // randomized traffic, including back-to-back recaptures
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j <= T; j++) p[j] = 8'($urandom);
      sel = 8'($urandom);
      step(($urandom_range(0, 9) < 3), p, sel, 8'($urandom));
    end

    // asynchronous reset in the middle of an evaluation window
    for (int j = 0; j <= T; j++) p[j] = 8'($urandom_range(1, 255));
    step(1'b1, p, 8'hFF, 8'h03);
    if (LAT != 0) step(1'b0, p, 8'hFF, 8'h03);
    check("r037_pre", 32'(vld4), 32'd1);
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check("r037_vld1", 32'(vld1), 32'd0);
    check("r037_val1", 32'(val1), 32'd0);
    check("r037_vld4", 32'(vld4), 32'd0);
    check("r037_val4", 32'(val4), 32'd0);
    @(posedge aclk);
    #1;
    check("r037_hold", 32'(vld4), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int n = 0; n < 5; n++) step(1'b0, p, 8'hFF, 8'($urandom));
    check("r037_after", 32'(vld4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
